// File: rtl/alu_div_scheduler.sv
// alu_div_scheduler
//   Shares one iterative unsigned restoring divider among THREADS thread ALUs.
//   Requests are granted round-robin from IDLE; the granted thread's operands
//   are latched, DATA_BITS restoring steps run MSB first, and a one-cycle
//   completion pulse is sent back to the owner together with the quotient.
//   Divide by zero skips the iterations and returns all-ones with dz set.
//
//   Optional build macro: ALU_DIV_REM_EN adds o_resp_rem (remainder output).
//
// Ports
//   clk            clock
//   reset          synchronous, active-high reset
//   i_enable       low freezes every register
//   i_req_valid    per-thread request level, held until its response is seen
//   i_req_rs       packed dividends, thread i at [i*DATA_BITS +: DATA_BITS]
//   i_req_rt       packed divisors, same packing
//   o_resp_valid   one-hot one-cycle completion pulse to the granted thread
//   o_resp_quot    quotient, qualified by o_resp_valid
//   o_resp_dz      divide-by-zero flag, qualified by o_resp_valid
//   o_busy         high whenever the divider is not idle
//   o_grant_id     thread currently owned / last served
//   o_resp_rem     remainder (ALU_DIV_REM_EN only); rs when divisor is zero
//
// States
//   S_IDLE | waiting for a request; grants on the edge a request is seen
//   S_ITER | one restoring step per edge, DATA_BITS steps in total
//   S_DONE | response pulse is on the outputs; next edge returns to idle
module alu_div_scheduler #(
    parameter int THREADS   = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_enable,
    input  logic [THREADS-1:0]           i_req_valid,
    input  logic [THREADS*DATA_BITS-1:0] i_req_rs,
    input  logic [THREADS*DATA_BITS-1:0] i_req_rt,
    output logic [THREADS-1:0]           o_resp_valid,
    output logic [DATA_BITS-1:0]         o_resp_quot,
    output logic                         o_resp_dz,
    output logic                         o_busy,
    output logic [$clog2(THREADS)-1:0]   o_grant_id
`ifdef ALU_DIV_REM_EN
    ,
    output logic [DATA_BITS-1:0]         o_resp_rem
`endif
);

    localparam int GW = $clog2(THREADS);
    localparam int CW = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [GW-1:0]          r_rr;
    logic [GW-1:0]          r_grant_id;
    logic [CW-1:0]          r_count;
    logic [DATA_BITS-1:0]   r_dividend;   // shifts left; quotient bits enter at the LSB
    logic [DATA_BITS-1:0]   r_divisor;
    logic [DATA_BITS-1:0]   r_rem;
    logic [THREADS-1:0]     r_resp_valid;
    logic [DATA_BITS-1:0]   r_resp_quot;
    logic                   r_resp_dz;
`ifdef ALU_DIV_REM_EN
    logic [DATA_BITS-1:0]   r_resp_rem;
`endif

    logic [DATA_BITS-1:0]   w_rs_arr [THREADS];
    logic [DATA_BITS-1:0]   w_rt_arr [THREADS];
    logic                   w_found;
    logic [GW-1:0]          w_winner;
    logic [GW-1:0]          w_idx;
    logic [GW-1:0]          w_rr_next;
    logic [DATA_BITS-1:0]   w_grant_rs;
    logic [DATA_BITS-1:0]   w_grant_rt;
    logic                   w_grant_dz;

    logic [DATA_BITS:0]     w_rem_shift;
    logic [DATA_BITS:0]     w_diff;
    logic                   w_ge;
    logic [DATA_BITS-1:0]   w_rem_next;
    logic [DATA_BITS-1:0]   w_quot_next;
    logic                   w_last;

    for (genvar g = 0; g < THREADS; g++) begin : g_unpack
        assign w_rs_arr[g] = i_req_rs[g*DATA_BITS +: DATA_BITS];
        assign w_rt_arr[g] = i_req_rt[g*DATA_BITS +: DATA_BITS];
    end

    // First requesting thread at or above the rr pointer, wrapping around.
    always_comb begin
        w_found    = 1'b0;
        w_winner   = '0;
        w_idx      = '0;
        w_grant_rs = '0;
        w_grant_rt = '0;
        for (int k = 0; k < THREADS; k++) begin
            w_idx = GW'((int'(r_rr) + k) % THREADS);
            if (!w_found && i_req_valid[w_idx]) begin
                w_found    = 1'b1;
                w_winner   = w_idx;
                w_grant_rs = w_rs_arr[w_idx];
                w_grant_rt = w_rt_arr[w_idx];
            end
        end
    end

    assign w_rr_next  = (w_winner == GW'(THREADS - 1)) ? '0 : w_winner + GW'(1);
    assign w_grant_dz = (w_grant_rt == '0);

    // Restoring step. The remainder stays below the divisor, so the shifted
    // value fits DATA_BITS+1 bits and the difference's MSB is the borrow.
    assign w_rem_shift = {r_rem, r_dividend[DATA_BITS-1]};
    assign w_diff      = w_rem_shift - {1'b0, r_divisor};
    assign w_ge        = ~w_diff[DATA_BITS];
    assign w_rem_next  = w_ge ? w_diff[DATA_BITS-1:0] : w_rem_shift[DATA_BITS-1:0];
    assign w_quot_next = {r_dividend[DATA_BITS-2:0], w_ge};
    assign w_last      = (r_count == CW'(DATA_BITS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else if (i_enable) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_next = w_grant_dz ? S_DONE : S_ITER;
                end
            end
            S_ITER: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr         <= '0;
            r_grant_id   <= '0;
            r_count      <= '0;
            r_dividend   <= '0;
            r_divisor    <= '0;
            r_rem        <= '0;
            r_resp_valid <= '0;
            r_resp_quot  <= '0;
            r_resp_dz    <= 1'b0;
`ifdef ALU_DIV_REM_EN
            r_resp_rem   <= '0;
`endif
        end else if (i_enable) begin
            r_resp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant_id <= w_winner;
                        r_rr       <= w_rr_next;
                        r_dividend <= w_grant_rs;
                        r_divisor  <= w_grant_rt;
                        r_rem      <= '0;
                        r_count    <= '0;
                        if (w_grant_dz) begin
                            r_resp_valid[w_winner] <= 1'b1;
                            r_resp_quot            <= '1;
                            r_resp_dz              <= 1'b1;
`ifdef ALU_DIV_REM_EN
                            r_resp_rem             <= w_grant_rs;
`endif
                        end
                    end
                end
                S_ITER: begin
                    r_dividend <= w_quot_next;
                    r_rem      <= w_rem_next;
                    r_count    <= r_count + CW'(1);
                    if (w_last) begin
                        r_resp_valid[r_grant_id] <= 1'b1;
                        r_resp_quot              <= w_quot_next;
                        r_resp_dz                <= 1'b0;
`ifdef ALU_DIV_REM_EN
                        r_resp_rem               <= w_rem_next;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_resp_valid = r_resp_valid;
    assign o_resp_quot  = r_resp_quot;
    assign o_resp_dz    = r_resp_dz;
    assign o_busy       = (r_state != S_IDLE);
    assign o_grant_id   = r_grant_id;
`ifdef ALU_DIV_REM_EN
    assign o_resp_rem   = r_resp_rem;
`endif

endmodule

// File: tb/tb_alu_div_scheduler.sv
module tb_alu_div_scheduler;

    localparam int T  = 4;
    localparam int DB = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b1;
    logic [T-1:0]    req_valid = '0;
    logic [T*DB-1:0] req_rs = '0;
    logic [T*DB-1:0] req_rt = '0;
    logic [T-1:0]    resp_valid;
    logic [DB-1:0]   resp_quot;
    logic            resp_dz;
    logic            busy;
    logic [1:0]      grant_id;
`ifdef ALU_DIV_REM_EN
    logic [DB-1:0]   resp_rem;
`endif

    alu_div_scheduler #(.THREADS(T), .DATA_BITS(DB)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_enable     (enable),
        .i_req_valid  (req_valid),
        .i_req_rs     (req_rs),
        .i_req_rt     (req_rt),
        .o_resp_valid (resp_valid),
        .o_resp_quot  (resp_quot),
        .o_resp_dz    (resp_dz),
        .o_busy       (busy),
        .o_grant_id   (grant_id)
`ifdef ALU_DIV_REM_EN
        ,
        .o_resp_rem   (resp_rem)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Behavioural model: a pending operation is a countdown of edges until its
    // pulse; the result comes straight from / and %.
    int           m_cnt = 0;
    int           m_rr = 0;
    int           m_grant = 0;
    int           m_q = 0;
    int           m_r = 0;
    int           m_w;
    int           m_rs;
    int           m_rt;
    bit           m_live = 1'b0;
    logic [T-1:0] e_valid = '0;
    int           e_quot = 0;
    int           e_dz = 0;
    int           e_rem = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0; m_rr = 0; m_grant = 0;
            e_valid = '0; e_quot = 0; e_dz = 0; e_rem = 0;
            m_live = 1'b1;
        end else if (enable && m_live) begin
            if (m_cnt > 0) begin
                m_cnt--;
                e_valid = '0;
                if (m_cnt == 0) begin
                    e_valid = T'(1) << m_grant;
                    e_quot  = m_q;
                    e_dz    = 0;
                    e_rem   = m_r;
                end
            end else if (e_valid != '0) begin
                e_valid = '0;
            end else if (req_valid != '0) begin
                m_w = -1;
                for (int k = 0; k < T; k++)
                    if (m_w < 0 && req_valid[(m_rr + k) % T]) m_w = (m_rr + k) % T;
                m_grant = m_w;
                m_rr    = (m_w + 1) % T;
                m_rs    = int'(req_rs[m_w*DB +: DB]);
                m_rt    = int'(req_rt[m_w*DB +: DB]);
                if (m_rt == 0) begin
                    e_valid = T'(1) << m_w;
                    e_quot  = 255;
                    e_dz    = 1;
                    e_rem   = m_rs;
                end else begin
                    m_q   = m_rs / m_rt;
                    m_r   = m_rs % m_rt;
                    m_cnt = DB;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("cyc_resp_valid", resp_valid, e_valid);
            check("cyc_busy", busy, (m_cnt > 0 || e_valid != '0) ? 1 : 0);
            check("cyc_grant_id", grant_id, m_grant);
            if (e_valid != '0) begin
                check("cyc_quot", resp_quot, e_quot);
                check("cyc_dz", resp_dz, e_dz);
`ifdef ALU_DIV_REM_EN
                check("cyc_rem", resp_rem, e_rem);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges from the call (first edge = grant edge) until a pulse.
    task automatic wait_pulse(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (resp_valid == '0 && n < limit);
        if (resp_valid == '0) begin
            checks++;
            errors++;
            $display("FAIL pulse_timeout actual=no pulse required=pulse within %0d edges", limit);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int n;
    int total;
    int pulses;
    logic [T-1:0] exp_v [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int exp_q3 [5] = '{33, 33, 34, 34, 33};
    int b_rs [3] = '{0, 255, 5};
    int b_rt [3] = '{1, 1, 255};
    int b_q  [3] = '{0, 255, 0};
    int b_r  [3] = '{0, 0, 5};

    initial begin
        #1;
        do_reset();
        check("reset_busy", busy, 0);
        check("reset_valid", resp_valid, 0);
        check("reset_quot", resp_quot, 0);
        check("reset_dz", resp_dz, 0);
        check("reset_grant", grant_id, 0);

        // Thread 1: 200 / 7
        req_rs[1*DB +: DB] = 8'd200;
        req_rt[1*DB +: DB] = 8'd7;
        req_valid = 4'b0010;
        wait_pulse(30, n);
        check("t1_latency", n, 9);
        check("t1_valid", resp_valid, 4'b0010);
        check("t1_quot", resp_quot, 28);
        check("t1_dz", resp_dz, 0);
        check("t1_grant", grant_id, 1);
`ifdef ALU_DIV_REM_EN
        check("t1_rem", resp_rem, 4);
`endif
        req_valid = '0;
        tick();
        check("t1_busy_after", busy, 0);
        check("t1_valid_after", resp_valid, 0);

        // Thread 2: divide by zero
        req_rs[2*DB +: DB] = 8'd55;
        req_rt[2*DB +: DB] = 8'd0;
        req_valid = 4'b0100;
        wait_pulse(30, n);
        check("dz_latency", n, 1);
        check("dz_valid", resp_valid, 4'b0100);
        check("dz_quot", resp_quot, 255);
        check("dz_flag", resp_dz, 1);
`ifdef ALU_DIV_REM_EN
        check("dz_rem", resp_rem, 55);
`endif
        req_valid = '0;
        tick();
        check("dz_busy_low", busy, 0);

        // Pulse must hold across a freeze
        req_valid = 4'b0100;
        wait_pulse(30, n);
        enable = 1'b0;
        tick();
        tick();
        check("freeze_pulse_hold", resp_valid, 4'b0100);
        check("freeze_busy_hold", busy, 1);
        enable = 1'b1;
        req_valid = '0;
        tick();
        check("freeze_pulse_clear", resp_valid, 0);

        // All threads requesting continuously
        do_reset();
        for (int i = 0; i < T; i++) begin
            req_rs[i*DB +: DB] = DB'(100 + i);
            req_rt[i*DB +: DB] = 8'd3;
        end
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_pulse(30, n);
            check("rr_latency", n, 9);
            check("rr_valid", resp_valid, exp_v[i]);
            check("rr_quot", resp_quot, exp_q3[i]);
            req_valid = req_valid & ~exp_v[i];
            tick();
            req_valid = req_valid | exp_v[i];
        end
        req_valid = '0;
        tick();

        // Reset while four iterations in
        req_rs[3*DB +: DB] = 8'd99;
        req_rt[3*DB +: DB] = 8'd5;
        req_valid = 4'b1000;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        req_valid = '0;
        tick();
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", resp_valid, 0);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (resp_valid != '0) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        req_rs[0 +: DB] = 8'd77;
        req_rt[0 +: DB] = 8'd4;
        req_valid = 4'b0001;
        wait_pulse(30, n);
        check("after_abort_latency", n, 9);
        check("after_abort_quot", resp_quot, 19);
        req_valid = '0;
        tick();

        // Freeze for five edges mid-iteration
        req_rs[1*DB +: DB] = 8'd255;
        req_rt[1*DB +: DB] = 8'd16;
        req_valid = 4'b0010;
        tick();
        tick();
        tick();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        enable = 1'b1;
        wait_pulse(30, n);
        total = 3 + 5 + n;
        check("en_latency", total, 14);
        check("en_quot", resp_quot, 15);
`ifdef ALU_DIV_REM_EN
        check("en_rem", resp_rem, 15);
`endif
        req_valid = '0;
        tick();

        // Boundary operands on thread 0
        for (int i = 0; i < 3; i++) begin
            req_rs[0 +: DB] = DB'(b_rs[i]);
            req_rt[0 +: DB] = DB'(b_rt[i]);
            req_valid = 4'b0001;
            wait_pulse(30, n);
            check("bnd_quot", resp_quot, b_q[i]);
            check("bnd_dz", resp_dz, 0);
`ifdef ALU_DIV_REM_EN
            check("bnd_rem", resp_rem, b_r[i]);
`endif
            req_valid = '0;
            tick();
        end

        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_div_scheduler.md
Name: alu_div_scheduler

Overview:
- Round-robin scheduler that shares one iterative 8-bit unsigned restoring divider among the per-thread ALUs of a core.
- Replaces per-thread single-cycle DIV hardware; each thread ALU raises a request during EXECUTE and waits for a completion pulse.
- Sits inside the core between thread ALUs and the register writeback path.

Parameters:
- THREADS, 4, number of requesting thread ALUs (2..8)
- DATA_BITS, 8, operand/quotient width; also the iteration count

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  when low, all state/registers hold (freeze)
- req_valid  in  THREADS  per-thread divide request, level, held until that thread's resp_valid seen
- req_rs  in  THREADS*DATA_BITS  packed dividends, thread i at [i*DATA_BITS +: DATA_BITS]
- req_rt  in  THREADS*DATA_BITS  packed divisors, same packing
- resp_valid  out  THREADS  one-cycle completion pulse to granted thread
- resp_quot  out  DATA_BITS  quotient, valid while any resp_valid bit high
- resp_dz  out  1  divide-by-zero flag, qualified by resp_valid
- busy  out  1  high whenever state != IDLE
- grant_id  out  $clog2(THREADS)  index of thread currently owned/last served

Behaviour:
- Reset: state=IDLE, resp_valid=0, resp_quot=0, resp_dz=0, grant_id=0, rr pointer=0 (thread 0 highest priority first), iteration counter=0. Reset mid-operation aborts silently; no resp_valid issued.
- enable=0: no state change, outputs hold (a pending resp_valid stays high until enable returns and the next edge clears it).
- States: IDLE, ITER, DONE.
- IDLE: if any req_valid bit set at edge, grant first set bit searching from rr pointer upward with wrap; latch rs/rt of granted thread, grant_id<=winner, rr pointer<=winner+1 (mod THREADS). If latched rt==0 go DONE with quot=all ones, dz=1; else remainder=0, counter=0, go ITER.
- ITER: one restoring step per edge, MSB first: rem={rem,dividend msb}; if rem>=divisor subtract and shift 1 into quotient else 0. After DATA_BITS steps (counter==DATA_BITS-1) go DONE.
- Entry to DONE registers resp_valid[grant_id]=1, resp_quot, resp_dz; exactly one bit set.
- DONE: next edge clears resp_valid, goes IDLE. IDLE does not grant on the edge leaving DONE.
- Latency: request sampled at edge E0 -> resp_valid high in cycle after E(DATA_BITS) (9 cycles for default); rt==0 -> resp_valid in cycle after E0+1... i.e. the cycle after E0.
- Requester rules: operands need only be stable at the granting edge; req_valid must drop by the edge following its resp_valid cycle. A still-high req_valid at next IDLE is treated as a new request.
- Fairness: a thread re-requesting immediately gets lowest priority; with all THREADS requesting, grants cycle 0,1,2,3,0...
- Arithmetic: unsigned; quotient = floor(rs/rt); remainder internal width DATA_BITS+1.

Optional Feature:
- Macro ALU_DIV_REM_EN. Defined: adds output port resp_rem [DATA_BITS] carrying remainder, registered with resp_quot; rt==0 gives resp_rem=rs; reset value 0. Undefined: port absent, remainder kept internal only.

Test Plan:
- Single request thread 1, rs=200, rt=7 -> resp_valid=4'b0010 exactly 9 cycles after grant edge, resp_quot=28, resp_dz=0 (resp_rem=4 with ALU_DIV_REM_EN).
- Divide by zero thread 2, rs=55, rt=0 -> resp_valid=4'b0100 one cycle after grant, resp_quot=8'hFF, resp_dz=1, busy low two cycles after grant.
- All four threads request continuously (rs=100+i, rt=3) -> grants 0,1,2,3 in order, quotients 33,33,34,34, no thread served twice before all served.
- Reset asserted during ITER (counter=4) -> next cycle busy=0, resp_valid=0, no pulse ever emitted for aborted op; following request completes normally.
- enable dropped for 5 cycles mid-ITER with rs=255, rt=16 -> latency extends by exactly 5 cycles, resp_quot=15.
- Boundary operands rs=0,rt=1 -> 0; rs=255,rt=1 -> 255; rs=5,rt=255 -> 0.
